// File: rtl/ascii_decoder.sv
// ascii_decoder: turns a UART byte stream of the form <hexA><op><hexB><term>
// into ALU operands plus a one-cycle start strobe.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   uart_in    : received ASCII byte, sampled when uart_valid=1
//   uart_valid : one-cycle strobe qualifying uart_in
//   alu_done   : one-cycle strobe from the ALU ending the current operation
//   op_a/op_b  : registered 32-bit operands, updated only with alu_start
//   opcode     : registered operator code (+:0 -:1 *:2 &:3 |:4)
//   alu_start  : one-cycle strobe, operands/opcode valid
//   parse_err  : one-cycle strobe, malformed expression detected
//   echo_out   : echoed byte (echo build only, else 0)
//   echo_valid : echo strobe (echo build only, else 0)
//
// Build option: define ASCII_DECODER_ECHO_EN to echo every received byte
// one cycle later; otherwise echo_out/echo_valid are tied to 0.

module ascii_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_in,
  input  logic        uart_valid,
  input  logic        alu_done,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [2:0]  opcode,
  output logic        alu_start,
  output logic        parse_err,
  output logic [7:0]  echo_out,
  output logic        echo_valid
);

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned OPC_W      = 3;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPA  = 3'd1,
    OPB  = 3'd2,
    WAIT = 3'd3,
    ERR  = 3'd4
  } state_t;

  // Character classification helpers
  function automatic logic is_hex(input logic [BYTE_W-1:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  function automatic logic [NIB_W-1:0] hex_val(input logic [BYTE_W-1:0] c);
    if (c <= 8'h39)      return NIB_W'(c - 8'h30);
    else if (c <= 8'h46) return NIB_W'(c - 8'h37);
    else                 return NIB_W'(c - 8'h57);
  endfunction

  function automatic logic is_op(input logic [BYTE_W-1:0] c);
    return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A) ||
           (c == 8'h26) || (c == 8'h7C);
  endfunction

  function automatic logic [OPC_W-1:0] op_code(input logic [BYTE_W-1:0] c);
    case (c)
      8'h2B:   return OPC_W'(0);
      8'h2D:   return OPC_W'(1);
      8'h2A:   return OPC_W'(2);
      8'h26:   return OPC_W'(3);
      8'h7C:   return OPC_W'(4);
      default: return OPC_W'(0);
    endcase
  endfunction

  state_t             state;
  logic [DATA_W-1:0]  acc_a;
  logic [DATA_W-1:0]  acc_b;
  logic [CNT_W-1:0]   cnt_a;
  logic [CNT_W-1:0]   cnt_b;
  logic [OPC_W-1:0]   code_q;

  logic               byte_hex;
  logic               byte_op;
  logic               byte_term;
  logic               byte_space;
  logic [NIB_W-1:0]   nibble;
  logic [OPC_W-1:0]   byte_code;

  // Decode of the current byte
  assign byte_hex   = is_hex(uart_in);
  assign byte_op    = is_op(uart_in);
  assign byte_term  = (uart_in == 8'h3D) || (uart_in == 8'h0D);
  assign byte_space = (uart_in == 8'h20);
  assign nibble     = hex_val(uart_in);
  assign byte_code  = op_code(uart_in);

  // Parser FSM with registered strobes and operand outputs.
  // On an error the partial expression is dropped immediately; if the
  // offending byte is itself a terminator the expression is already over,
  // so the parser returns straight to IDLE instead of waiting in ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_a     <= '0;
      acc_b     <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      code_q    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      opcode    <= '0;
      alu_start <= 1'b0;
      parse_err <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      parse_err <= 1'b0;
      case (state)
        IDLE: begin
          if (uart_valid) begin
            if (byte_hex) begin
              acc_a <= DATA_W'(nibble);
              cnt_a <= CNT_W'(1);
              state <= OPA;
            end else if (!(byte_term || byte_space)) begin
              parse_err <= 1'b1;
              state     <= ERR;
            end
          end
        end

        OPA: begin
          if (uart_valid && !byte_space) begin
            if (byte_hex && (cnt_a != CNT_W'(MAX_DIGITS))) begin
              acc_a <= {acc_a[DATA_W-NIB_W-1:0], nibble};
              cnt_a <= cnt_a + CNT_W'(1);
            end else if (byte_op) begin
              code_q <= byte_code;
              state  <= OPB;
            end else begin
              parse_err <= 1'b1;
              acc_a     <= '0;
              acc_b     <= '0;
              cnt_a     <= '0;
              cnt_b     <= '0;
              code_q    <= '0;
              state     <= byte_term ? IDLE : ERR;
            end
          end
        end

        OPB: begin
          if (uart_valid && !byte_space) begin
            if (byte_hex && (cnt_b != CNT_W'(MAX_DIGITS))) begin
              acc_b <= {acc_b[DATA_W-NIB_W-1:0], nibble};
              cnt_b <= cnt_b + CNT_W'(1);
            end else if (byte_term && (cnt_b != '0)) begin
              op_a      <= acc_a;
              op_b      <= acc_b;
              opcode    <= code_q;
              alu_start <= 1'b1;
              state     <= WAIT;
            end else begin
              parse_err <= 1'b1;
              acc_a     <= '0;
              acc_b     <= '0;
              cnt_a     <= '0;
              cnt_b     <= '0;
              code_q    <= '0;
              state     <= byte_term ? IDLE : ERR;
            end
          end
        end

        // Incoming bytes are dropped until the ALU finishes
        WAIT: begin
          if (alu_done) begin
            acc_a  <= '0;
            acc_b  <= '0;
            cnt_a  <= '0;
            cnt_b  <= '0;
            code_q <= '0;
            state  <= IDLE;
          end
        end

        // Discard the rest of a bad expression up to its terminator
        ERR: begin
          if (uart_valid && byte_term) begin
            acc_a  <= '0;
            acc_b  <= '0;
            cnt_a  <= '0;
            cnt_b  <= '0;
            code_q <= '0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ASCII_DECODER_ECHO_EN
  // Echo every received byte one cycle later, regardless of parser state
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_out   <= '0;
      echo_valid <= 1'b0;
    end else begin
      echo_valid <= uart_valid;
      if (uart_valid) begin
        echo_out <= uart_in;
      end
    end
  end
`else
  assign echo_out   = '0;
  assign echo_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ascii_decoder.sv
// Testbench for ascii_decoder: table of expressions, hand sequences for the
// multi-cycle corners, and randomized traffic against a grammar-level model.

module tb_ascii_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  uart_in;
  logic        uart_valid;
  logic        alu_done;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  opcode;
  logic        alu_start;
  logic        parse_err;
  logic [7:0]  echo_out;
  logic        echo_valid;

  ascii_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .uart_in    (uart_in),
    .uart_valid (uart_valid),
    .alu_done   (alu_done),
    .op_a       (op_a),
    .op_b       (op_b),
    .opcode     (opcode),
    .alu_start  (alu_start),
    .parse_err  (parse_err),
    .echo_out   (echo_out),
    .echo_valid (echo_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int starts_seen = 0;
  int errs_seen = 0;

  string lc  = "0123456789abcdef";
  string uc  = "0123456789ABCDEF";
  string ops = "+-*&|";

  // Reference model state
  logic [7:0]  mq[$];
  bit          m_busy;
  bit          m_discard;
  logic        m_start;
  logic        m_err;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [2:0]  m_op;
  logic [7:0]  m_echo;
  logic        m_echo_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hex_digit(input logic [7:0] c);
    for (int i = 0; i < 16; i++)
      if (c == 8'(lc[i]) || c == 8'(uc[i])) return i;
    return -1;
  endfunction

  function automatic int op_index(input logic [7:0] c);
    for (int i = 0; i < 5; i++)
      if (c == 8'(ops[i])) return i;
    return -1;
  endfunction

  function automatic bit is_term(input logic [7:0] c);
    return (c == 8'h3D) || (c == 8'h0D);
  endfunction

  // Grammar check of the collected expression: 0 = valid prefix,
  // 1 = complete expression, 2 = cannot become valid.
  function automatic int classify(output logic [31:0] a, output logic [31:0] b,
                                  output logic [2:0] op);
    int i = 0;
    int na = 0;
    int nb = 0;
    a = 0; b = 0; op = 0;
    while (i < mq.size() && hex_digit(mq[i]) >= 0) begin
      a = a * 16 + 32'(hex_digit(mq[i]));
      na++; i++;
    end
    if (na == 0 || na > 8) return 2;
    if (i == mq.size()) return 0;
    if (op_index(mq[i]) < 0) return 2;
    op = 3'(op_index(mq[i]));
    i++;
    while (i < mq.size() && hex_digit(mq[i]) >= 0) begin
      b = b * 16 + 32'(hex_digit(mq[i]));
      nb++; i++;
    end
    if (nb > 8) return 2;
    if (i == mq.size()) return 0;
    if (is_term(mq[i]) && nb >= 1 && i == mq.size() - 1) return 1;
    return 2;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [7:0] b, input bit d);
    logic [31:0] ca, cb;
    logic [2:0]  cop;
    int res;
    m_start = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_busy = 0; m_discard = 0; mq.delete();
      m_a = 0; m_b = 0; m_op = 0; m_echo = 0; m_echo_v = 0;
      return;
    end
`ifdef ASCII_DECODER_ECHO_EN
    m_echo_v = v;
    if (v) m_echo = b;
`else
    m_echo_v = 1'b0;
    m_echo   = 8'h00;
`endif
    if (m_busy) begin
      if (d) m_busy = 0;
    end else if (v) begin
      if (m_discard) begin
        if (is_term(b)) m_discard = 0;
      end else if (b == 8'h20) begin
        m_discard = 0;
      end else if (mq.size() == 0 && is_term(b)) begin
        m_discard = 0;
      end else begin
        mq.push_back(b);
        res = classify(ca, cb, cop);
        if (res == 2) begin
          m_err = 1'b1;
          m_discard = !is_term(b);
          mq.delete();
        end else if (res == 1) begin
          m_start = 1'b1;
          m_a = ca; m_b = cb; m_op = cop;
          m_busy = 1;
          mq.delete();
        end
      end
    end
  endtask

  // One clock cycle: drive on the falling edge, compare after the rising edge
  task automatic tick(input bit r, input bit v, input logic [7:0] b, input bit d);
    @(negedge clk);
    rst = r; uart_valid = v; uart_in = b; alu_done = d;
    @(posedge clk);
    model_step(r, v, b, d);
    #1;
    chk("alu_start",  32'(alu_start),  32'(m_start));
    chk("parse_err",  32'(parse_err),  32'(m_err));
    chk("op_a",       op_a,            m_a);
    chk("op_b",       op_b,            m_b);
    chk("opcode",     32'(opcode),     32'(m_op));
    chk("echo_valid", 32'(echo_valid), 32'(m_echo_v));
    chk("echo_out",   32'(echo_out),   32'(m_echo));
    starts_seen += int'(alu_start);
    errs_seen   += int'(parse_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      tick(1'b0, 1'b1, 8'(s[i]), 1'b0);
      idle(1);
    end
  endtask

  typedef struct {
    string       s;
    int          n_start;
    int          n_err;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] rq[$];
  logic [7:0] echo_exp[4];
  string echo_str;

  initial begin
    rst = 1'b1; uart_valid = 1'b0; uart_in = 8'h00; alu_done = 1'b0;

    // Reset state
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reset op_a", op_a, 32'h0);
    chk("reset op_b", op_b, 32'h0);
    chk("reset opcode", 32'(opcode), 32'h0);
    chk("reset alu_start", 32'(alu_start), 32'h0);
    chk("reset parse_err", 32'(parse_err), 32'h0);
    chk("reset echo_valid", 32'(echo_valid), 32'h0);
    chk("reset echo_out", 32'(echo_out), 32'h0);
    idle(2);

    // Table of whole expressions; error rows expect the previous operands held
    vecs[0]  = '{"1a+2B=",               1, 0, 32'h0000001A, 32'h0000002B, 3'd0};
    vecs[1]  = '{"FFFFFFFF*ffffffff\015", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2};
    vecs[2]  = '{"123456789+1=",         0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2};
    vecs[3]  = '{"5+=",                  0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2};
    vecs[4]  = '{"3 | 4=",               1, 0, 32'h00000003, 32'h00000004, 3'd4};
    vecs[5]  = '{"x=",                   0, 1, 32'h00000003, 32'h00000004, 3'd4};
    vecs[6]  = '{"12345678|87654321=",   1, 0, 32'h12345678, 32'h87654321, 3'd4};
    vecs[7]  = '{"0-0=",                 1, 0, 32'h00000000, 32'h00000000, 3'd1};
    vecs[8]  = '{" 8 & c =",             1, 0, 32'h00000008, 32'h0000000C, 3'd3};
    vecs[9]  = '{"7+8+9=",               0, 1, 32'h00000008, 32'h0000000C, 3'd3};
    vecs[10] = '{"+5=",                  0, 1, 32'h00000008, 32'h0000000C, 3'd3};
    vecs[11] = '{"== \015=",             0, 0, 32'h00000008, 32'h0000000C, 3'd3};

    for (int k = 0; k < 12; k++) begin
      starts_seen = 0;
      errs_seen = 0;
      send_str(vecs[k].s);
      idle(2);
      chk($sformatf("vec%0d starts", k), 32'(starts_seen), 32'(vecs[k].n_start));
      chk($sformatf("vec%0d errs", k),   32'(errs_seen),   32'(vecs[k].n_err));
      chk($sformatf("vec%0d op_a", k),   op_a,             vecs[k].a);
      chk($sformatf("vec%0d op_b", k),   op_b,             vecs[k].b);
      chk($sformatf("vec%0d opcode", k), 32'(opcode),      32'(vecs[k].op));
      if (vecs[k].n_start > 0) begin
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        idle(1);
      end
    end

    // alu_start exactly in the cycle after the terminator, for one cycle
    send_str("6*7");
    tick(1'b0, 1'b1, 8'h3D, 1'b0);
    chk("start after term", 32'(alu_start), 32'h1);
    idle(1);
    chk("start one cycle", 32'(alu_start), 32'h0);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);

    // parse_err exactly in the cycle after the offending byte
    send_str("5+");
    tick(1'b0, 1'b1, 8'h3D, 1'b0);
    chk("err after term", 32'(parse_err), 32'h1);
    idle(1);
    chk("err one cycle", 32'(parse_err), 32'h0);
    send_str("3 | 4=");
    chk("recover op_a", op_a, 32'h3);
    chk("recover opcode", 32'(opcode), 32'h4);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);

    // Bytes dropped while waiting for the ALU
    starts_seen = 0;
    send_str("7-2=");
    send_str("9&1=");
    chk("wait drop starts", 32'(starts_seen), 32'h1);
    chk("wait drop op_a", op_a, 32'h7);
    chk("wait drop op_b", op_b, 32'h2);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    send_str("9&1=");
    chk("after done op_a", op_a, 32'h9);
    chk("after done op_b", op_b, 32'h1);
    chk("after done opcode", 32'(opcode), 32'h3);

    // alu_done together with a byte in WAIT: done wins, byte lost
    tick(1'b0, 1'b1, 8'h2B, 1'b1);
    starts_seen = 0;
    errs_seen = 0;
    send_str("2+2=");
    chk("done+byte starts", 32'(starts_seen), 32'h1);
    chk("done+byte errs", 32'(errs_seen), 32'h0);
    chk("done+byte op_a", op_a, 32'h2);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);

    // Reset mid-expression abandons it silently and clears the outputs
    starts_seen = 0;
    errs_seen = 0;
    send_str("12+3");
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    idle(1);
    chk("rst mid starts", 32'(starts_seen), 32'h0);
    chk("rst mid errs", 32'(errs_seen), 32'h0);
    chk("rst mid op_a", op_a, 32'h0);
    chk("rst mid op_b", op_b, 32'h0);
    send_str("4-1=");
    chk("post rst op_a", op_a, 32'h4);
    chk("post rst op_b", op_b, 32'h1);
    chk("post rst opcode", 32'(opcode), 32'h1);

    // Reset in WAIT, also dominating a byte in the same cycle
    tick(1'b1, 1'b1, 8'h37, 1'b0);
    errs_seen = 0;
    starts_seen = 0;
    send_str("+1=");
    chk("rst dom errs", 32'(errs_seen), 32'h1);
    chk("rst dom starts", 32'(starts_seen), 32'h0);
    chk("rst dom op_a", op_a, 32'h0);

    // alu_done outside WAIT is ignored
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    send_str("3*3=");
    chk("idle done op_a", op_a, 32'h3);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);

    // Echo timing
    echo_str = "A+B=";
    echo_exp[0] = 8'h41; echo_exp[1] = 8'h2B; echo_exp[2] = 8'h42; echo_exp[3] = 8'h3D;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 8'(echo_str[i]), 1'b0);
`ifdef ASCII_DECODER_ECHO_EN
      chk("echo valid", 32'(echo_valid), 32'h1);
      chk("echo byte", 32'(echo_out), 32'(echo_exp[i]));
`else
      chk("no echo valid", 32'(echo_valid), 32'h0);
      chk("no echo byte", 32'(echo_out), 32'h0);
`endif
      idle(1);
      chk("echo gap", 32'(echo_valid), 32'h0);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);

    // Randomized expressions against the model
    for (int n = 0; n < 300; n++) begin
      int na, nb;
      rq.delete();
      na = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(1, 8));
      nb = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(1, 8));
      for (int i = 0; i < na; i++) begin
        int d = int'($urandom_range(0, 15));
        rq.push_back($urandom_range(0, 1) ? 8'(uc[d]) : 8'(lc[d]));
        if ($urandom_range(0, 15) == 0) rq.push_back(8'h20);
      end
      if ($urandom_range(0, 19) == 0) rq.push_back(8'($urandom_range(33, 126)));
      else rq.push_back(8'(ops[$urandom_range(0, 4)]));
      for (int i = 0; i < nb; i++) begin
        int d = int'($urandom_range(0, 15));
        rq.push_back($urandom_range(0, 1) ? 8'(uc[d]) : 8'(lc[d]));
      end
      if ($urandom_range(0, 19) != 0) rq.push_back($urandom_range(0, 1) ? 8'h3D : 8'h0D);
      foreach (rq[i]) begin
        tick(1'b0, 1'b1, rq[i], $urandom_range(0, 7) == 0);
        for (int g = int'($urandom_range(0, 2)); g > 0; g--)
          tick($urandom_range(0, 199) == 0, 1'b0, 8'h00, $urandom_range(0, 3) == 0);
      end
      for (int g = int'($urandom_range(1, 4)); g > 0; g--)
        tick(1'b0, 1'b0, 8'h00, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
